// File: rtl/puf_pkg.sv
// Shared constants, FSM state codes and select-pair helper for the PUF response controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package puf_pkg;

  localparam int NBITS      = 16;
  localparam int CNT_W      = 16;
  localparam int WINDOW_DEF = 1024;
  localparam int SETTLE_DEF = 4;

  // Controller states: one measurement per response bit, cycled 16 times.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CLEAR   = 3'd1;
  localparam state_t ST_MEASURE = 3'd2;
  localparam state_t ST_SETTLE  = 3'd3;
  localparam state_t ST_COMPARE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Chain B oscillator sits 1..8 positions after chain A, so the pair never collides.
  function automatic logic [3:0] sel_b_of(input logic [3:0] sel_a, input logic [2:0] off);
    return sel_a + 4'd1 + {1'b0, off};
  endfunction

endpackage

// File: rtl/puf_win_timer.sv
// Loadable down-counter with zero flag that times the measure and settle phases.
// Latency: load takes effect at the next edge; zero is a combinational decode of the count.
// Backpressure: none; dec is ignored once the count has reached zero.
module puf_win_timer
  import puf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Load has priority over decrement; the counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/puf_resp_ctrl.sv
// Ring-oscillator PUF sequencer: per bit clear, gate WINDOW cycles, settle, compare chains A/B.
// Latency: done pulses 16*(WINDOW+SETTLE+2)+1 cycles after the start edge.
// Backpressure: start is only honoured in IDLE; ena low aborts a run back to IDLE with no done.
module puf_resp_ctrl
  import puf_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  output logic             ro_en,
  output logic             cnt_clr,
  output logic [3:0]       sel_a,
  output logic [3:0]       sel_b,
  output logic [NBITS-1:0] response,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       bit_idx;
  logic [7:0]       seed_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             accept;
  logic             cmp_fire;
  logic             last_bit;
  logic [3:0]       bit_nxt;
  logic [3:0]       sel_a_nxt;
  logic             unused_seed_msb;

  // Seed bit 7 is captured for completeness but does not steer either select.
  assign unused_seed_msb = seed_q[7];

  assign accept    = (state == ST_IDLE) && start && ena;
  assign cmp_fire  = (state == ST_COMPARE) && ena;
  assign last_bit  = (bit_idx == 4'(NBITS - 1));
  assign bit_nxt   = bit_idx + 4'd1;
  assign sel_a_nxt = bit_nxt ^ seed_q[3:0];

  // Window timer is loaded on the way into each timed phase.
  assign tmr_load = (state == ST_CLEAR) || ((state == ST_MEASURE) && tmr_zero);
  assign tmr_val  = (state == ST_CLEAR) ? CNT_W'(WINDOW - 1) : CNT_W'(SETTLE - 1);
  assign tmr_dec  = (state == ST_MEASURE) || (state == ST_SETTLE);

  puf_win_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are pure state decodes, so reset clears them immediately.
  assign cnt_clr = (state == ST_CLEAR);
  assign ro_en   = (state == ST_MEASURE);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // Next-state: phase sequencing per bit, with ena low overriding everything outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start && ena) state_nxt = ST_CLEAR;
      ST_CLEAR:   state_nxt = ST_MEASURE;
      ST_MEASURE: if (tmr_zero) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (tmr_zero) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = last_bit ? ST_DONE : ST_CLEAR;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && !ena) begin
      state_nxt = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Seed capture, bit index and select pair; selects change only when a new bit begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q  <= '0;
      bit_idx <= '0;
      sel_a   <= '0;
      sel_b   <= '0;
    end else if (accept) begin
      seed_q  <= seed;
      bit_idx <= '0;
      sel_a   <= seed[3:0];
      sel_b   <= sel_b_of(seed[3:0], seed[6:4]);
    end else if (cmp_fire && !last_bit) begin
      bit_idx <= bit_nxt;
      sel_a   <= sel_a_nxt;
      sel_b   <= sel_b_of(sel_a_nxt, seed_q[6:4]);
    end
  end

  // Response and saturation flag: cleared on accept, updated only in COMPARE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      response <= '0;
      sat      <= 1'b0;
    end else if (accept) begin
      response <= '0;
      sat      <= 1'b0;
    end else if (cmp_fire) begin
      response[bit_idx] <= (count_a > count_b);
      sat <= sat | (count_a == {CNT_W{1'b1}}) | (count_b == {CNT_W{1'b1}});
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Randomized self-checking bench for puf_resp_ctrl with WINDOW=8, SETTLE=2.
// Latency: expects done 193 cycles after the accepting edge.
// Backpressure: exercises start-while-busy, ena abort and mid-run reset.
module tb_puf_resp_ctrl;

  localparam int W        = 8;
  localparam int S        = 2;
  localparam int PER      = W + S + 2;
  localparam int DONE_CYC = 16 * PER + 1;
  localparam int NCYC     = DONE_CYC + 7;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  seed;
  logic [15:0] count_a;
  logic [15:0] count_b;
  logic        ro_en;
  logic        cnt_clr;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [15:0] response;
  logic        busy;
  logic        done;
  logic        sat;

  int n_chk  = 0;
  int n_fail = 0;

  puf_resp_ctrl #(.WINDOW(W), .SETTLE(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .seed     (seed),
    .count_a  (count_a),
    .count_b  (count_b),
    .ro_en    (ro_en),
    .cnt_clr  (cnt_clr),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .response (response),
    .busy     (busy),
    .done     (done),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] all_outs();
    return {ro_en, cnt_clr, sel_a, sel_b, response, busy, done, sat};
  endfunction

  // mode 0: a=100,b=50 const; 1: a=b=200; 2: random, a=FFFF only at bit 3 compare;
  // 3: small random values with rare saturation.
  // abort_cyc/rst_cyc/pulse_cyc: 0 = unused, else the cycle (after start edge) of the event.
  task automatic run(input logic [7:0] sd, input int mode, input int abort_cyc,
                     input int rst_cyc, input int pulse_cyc);
    logic [15:0] ca [0:NCYC];
    logic [15:0] cb [0:NCYC];
    logic [15:0] exp_resp;
    logic        exp_sat;
    logic [3:0]  exp_vec;
    logic [3:0]  ea;
    logic [3:0]  eb;
    int          stop_cyc;
    int          done_cnt;
    logic [15:0] hold_resp;

    for (int c = 0; c <= NCYC; c++) begin
      case (mode)
        0: begin ca[c] = 16'd100; cb[c] = 16'd50; end
        1: begin ca[c] = 16'd200; cb[c] = 16'd200; end
        2: begin
          ca[c] = (c == 4 * PER) ? 16'hFFFF : 16'($urandom_range(0, 1000));
          cb[c] = 16'($urandom_range(0, 1000));
        end
        default: begin
          ca[c] = ($urandom_range(0, 63) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
          cb[c] = ($urandom_range(0, 63) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
        end
      endcase
    end

    // Reference: bit k is decided by the counts present in cycle (k+1)*PER.
    stop_cyc = (abort_cyc != 0) ? abort_cyc : rst_cyc;
    exp_resp = '0;
    exp_sat  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int cc;
      cc = (k + 1) * PER;
      if (stop_cyc == 0 || cc < stop_cyc) begin
        exp_resp[k] = (ca[cc] > cb[cc]);
        if (ca[cc] == 16'hFFFF || cb[cc] == 16'hFFFF) exp_sat = 1'b1;
      end
    end
    if (rst_cyc != 0) begin
      exp_resp = '0;
      exp_sat  = 1'b0;
    end

    ena     = 1'b1;
    start   = 1'b1;
    seed    = sd;
    count_a = ca[0];
    count_b = cb[0];
    step();
    start    = 1'b0;
    done_cnt = 0;

    for (int c = 1; c <= NCYC; c++) begin
      bit live;
      int  p;
      int  k;
      ena     = !(abort_cyc != 0 && c >= abort_cyc);
      start   = (c == pulse_cyc);
      count_a = ca[c];
      count_b = cb[c];
      live    = (c <= DONE_CYC) && (stop_cyc == 0 || c <= stop_cyc);
      p       = (c - 1) % PER;
      k       = (c - 1) / PER;
      exp_vec = {live, live && c == DONE_CYC,
                 live && c < DONE_CYC && p == 0,
                 live && c < DONE_CYC && p >= 1 && p <= W};
      check("busy_done_clr_ro", {28'd0, busy, done, cnt_clr, ro_en}, {28'd0, exp_vec});
      if (c == 1) check("sat_cleared_at_start", {31'd0, sat}, 32'd0);
      if (live && c < DONE_CYC && (p == 0 || p == PER - 1)) begin
        ea = 4'(k) ^ sd[3:0];
        eb = 4'(ea + 4'd1 + {1'b0, sd[6:4]});
        check("sel_pair", {24'd0, sel_a, sel_b}, {24'd0, ea, eb});
      end
      if (done) done_cnt++;
      if (c == rst_cyc) begin
        #1 rst_n = 1'b0;
        #1 check("reset_async_outputs", {3'd0, all_outs()}, 32'd0);
        #2 rst_n = 1'b1;
      end
      step();
    end

    check("done_count", done_cnt, (stop_cyc == 0) ? 32'd1 : 32'd0);
    check("response", {16'd0, response}, {16'd0, exp_resp});
    check("sat", {31'd0, sat}, {31'd0, exp_sat});

    // In IDLE the response and sat must hold whatever the counters do, and nothing restarts.
    ena       = 1'b1;
    hold_resp = response;
    for (int i = 0; i < 3; i++) begin
      count_a = 16'($urandom);
      count_b = 16'($urandom);
      step();
    end
    check("response_hold", {16'd0, response}, {16'd0, exp_resp});
    check("sat_hold", {31'd0, sat}, {31'd0, exp_sat});
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("hold_unchanged", {16'd0, response}, {16'd0, hold_resp});
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    start   = 1'b0;
    seed    = '0;
    count_a = '0;
    count_b = '0;
    #12;
    check("reset_state", {3'd0, all_outs()}, 32'd0);
    rst_n = 1'b1;
    step();

    // Start with ena low must not launch a run.
    start = 1'b1;
    step();
    check("start_without_ena", {31'd0, busy}, 32'd0);
    start = 1'b0;

    run(8'h00, 0, 0, 0, 0);
    run(8'h35, 1, 0, 0, 50);
    run(8'h35, 2, 0, 0, 0);
    run(8'($urandom), 1, 0, 0, 0);
    run(8'($urandom), 3, 1 + 5 * PER + 3, 0, 0);
    run(8'($urandom), 3, 0, 2 * PER + 10, 0);
    for (int i = 0; i < 4; i++) begin
      run(8'($urandom), 3, 0, 0, $urandom_range(2, DONE_CYC - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
